dco_counter_osc: RTL

- Counter-based digitally controlled oscillator for the ADPLL.
- Consumes the signed control code produced by the loop filter and generates the DCO output clock by counting gen_clk_i cycles.
- Per-half-period length: centre value minus the scaled code, clamped to legal bounds.
- Code is sampled only at half-period boundaries, so the output is glitch-free and never produces a runt pulse.

---
 rtl/dco_counter_osc_pkg.sv | 13 +
 rtl/dco_half_period_calc.sv | 42 ++++
 rtl/dco_counter_osc.sv | 111 +++++++++++
 3 files changed

// File: rtl/dco_counter_osc_pkg.sv
// Shared constants for the counter-based DCO: FSM state encoding and default
// half-period settings.
package dco_counter_osc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam int DEF_CENTRE_HALF = 32;
    localparam int DEF_MIN_HALF    = 2;
    localparam int DEF_MAX_HALF    = 255;

endpackage

// File: rtl/dco_half_period_calc.sv
// Combinational half-period length: centre minus the scaled control code,
// clamped into the legal counter range.
module dco_half_period_calc
    import dco_counter_osc_pkg::*;
#(
    parameter int DCO_CC_WIDTH = 5,
    parameter int COUNT_WIDTH  = 8,
    parameter int CENTRE_HALF  = DEF_CENTRE_HALF,
    parameter int GAIN_SHIFT   = 0,
    parameter int MIN_HALF     = DEF_MIN_HALF,
    parameter int MAX_HALF     = DEF_MAX_HALF
) (
    input  logic signed [DCO_CC_WIDTH-1:0] i_dcoCc,
    output logic        [COUNT_WIDTH-1:0]  o_halfPeriod
);

    // Wide enough that the most negative code at full gain cannot overflow.
    localparam int CALC_W = COUNT_WIDTH + GAIN_SHIFT + DCO_CC_WIDTH + 1;

    localparam logic signed [CALC_W-1:0] C_CENTRE = CALC_W'(CENTRE_HALF);
    localparam logic signed [CALC_W-1:0] C_MIN    = CALC_W'(MIN_HALF);
    localparam logic signed [CALC_W-1:0] C_MAX    = CALC_W'(MAX_HALF);

    logic signed [CALC_W-1:0] w_ccExt;
    logic signed [CALC_W-1:0] w_scaled;
    logic signed [CALC_W-1:0] w_half;

    assign w_ccExt  = {{(CALC_W-DCO_CC_WIDTH){i_dcoCc[DCO_CC_WIDTH-1]}}, i_dcoCc};
    assign w_scaled = w_ccExt <<< GAIN_SHIFT;
    assign w_half   = C_CENTRE - w_scaled;

    always_comb begin
        if (w_half < C_MIN) begin
            o_halfPeriod = COUNT_WIDTH'(MIN_HALF);
        end else if (w_half > C_MAX) begin
            o_halfPeriod = COUNT_WIDTH'(MAX_HALF);
        end else begin
            o_halfPeriod = w_half[COUNT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dco_counter_osc.sv
// Counter-based DCO: each output half-period counts a clamped number of
// gen_clk_i cycles, with the control code sampled only at phase boundaries.
module dco_counter_osc
    import dco_counter_osc_pkg::*;
#(
    parameter int DCO_CC_WIDTH = 5,
    parameter int COUNT_WIDTH  = 8,
    parameter int CENTRE_HALF  = DEF_CENTRE_HALF,
    parameter int GAIN_SHIFT   = 0,
    parameter int MIN_HALF     = DEF_MIN_HALF,
    parameter int MAX_HALF     = DEF_MAX_HALF
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
    output logic                           dco_clk_o,
    output logic                           dco_edge_o,
    output logic signed [DCO_CC_WIDTH-1:0] cc_applied_o,
    output logic                           running_o
);

    logic [COUNT_WIDTH-1:0]         w_halfPeriod;
    logic [COUNT_WIDTH-1:0]         w_loadCount;

    logic [1:0]                     r_state;
    logic [COUNT_WIDTH-1:0]         r_count;
    logic                           r_dcoClk;
    logic                           r_dcoEdge;
    logic signed [DCO_CC_WIDTH-1:0] r_ccApplied;
    logic                           r_running;

    dco_half_period_calc #(
        .DCO_CC_WIDTH (DCO_CC_WIDTH),
        .COUNT_WIDTH  (COUNT_WIDTH),
        .CENTRE_HALF  (CENTRE_HALF),
        .GAIN_SHIFT   (GAIN_SHIFT),
        .MIN_HALF     (MIN_HALF),
        .MAX_HALF     (MAX_HALF)
    ) u_halfCalc (
        .i_dcoCc      (dco_cc_i),
        .o_halfPeriod (w_halfPeriod)
    );

    // Clamp guarantees w_halfPeriod >= 1, so this never wraps.
    assign w_loadCount = w_halfPeriod - COUNT_WIDTH'(1);

    // Enable is only looked at when idle or at the end of a LOW phase, so a
    // started period always completes and the output ends low.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_dcoClk    <= 1'b0;
            r_dcoEdge   <= 1'b0;
            r_ccApplied <= '0;
            r_running   <= 1'b0;
        end else begin
            r_dcoEdge <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dcoClk <= 1'b0;
                    if (enable_i) begin
                        r_state     <= ST_HIGH;
                        r_dcoClk    <= 1'b1;
                        r_dcoEdge   <= 1'b1;
                        r_count     <= w_loadCount;
                        r_ccApplied <= dco_cc_i;
                        r_running   <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (r_count != '0) begin
                        r_count <= r_count - COUNT_WIDTH'(1);
                    end else begin
                        r_state     <= ST_LOW;
                        r_dcoClk    <= 1'b0;
                        r_count     <= w_loadCount;
                        r_ccApplied <= dco_cc_i;
                    end
                end
                ST_LOW: begin
                    if (r_count != '0) begin
                        r_count <= r_count - COUNT_WIDTH'(1);
                    end else if (enable_i) begin
                        r_state     <= ST_HIGH;
                        r_dcoClk    <= 1'b1;
                        r_dcoEdge   <= 1'b1;
                        r_count     <= w_loadCount;
                        r_ccApplied <= dco_cc_i;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_dcoClk  <= 1'b0;
                    r_count   <= '0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign dco_clk_o    = r_dcoClk;
    assign dco_edge_o   = r_dcoEdge;
    assign cc_applied_o = r_ccApplied;
    assign running_o    = r_running;

endmodule
